// File: rtl/assoc_cache_ctrl_pkg.sv
// rtl/assoc_cache_ctrl_pkg.sv - shared request/response structs, FSM states and bus widths for the cache
package cache_structs_def;

    localparam int CACHE_ADDR_WIDTH = 32;
    localparam int CACHE_DATA_WIDTH = 32;

    typedef struct packed {
        logic [CACHE_ADDR_WIDTH-1:0] addr;
        logic                        rw;
        logic                        cs;
    } processor_request_t;

    typedef struct packed {
        logic [CACHE_ADDR_WIDTH-1:0] addr;
        logic [CACHE_DATA_WIDTH-1:0] data;
        logic                        rw;
        logic                        valid;
    } memory_request_t;

    typedef struct packed {
        logic [CACHE_DATA_WIDTH-1:0] data;
        logic                        ready;
    } memory_response_t;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE,
        DONE
    } cache_state_t;

endpackage

// File: rtl/assoc_cache_ctrl_if.sv
// rtl/assoc_cache_ctrl_if.sv - processor and memory handshake signals of the cache controller
interface assoc_cache_ctrl_if;
    import cache_structs_def::*;

    processor_request_t proc_req;
    logic               proc_req_dr;
    logic               hit_out;
    memory_request_t    mem_req;
    memory_response_t   mem_res;

    // master = processor plus memory controller, slave = the cache
    modport master (
        output proc_req,
        input  proc_req_dr,
        input  hit_out,
        input  mem_req,
        output mem_res
    );

    modport slave (
        input  proc_req,
        output proc_req_dr,
        output hit_out,
        output mem_req,
        input  mem_res
    );

endinterface

// File: rtl/assoc_cache_ctrl_way_array.sv
// rtl/assoc_cache_ctrl_way_array.sv - per-way valid/dirty/tag/data storage with parallel tag compare
module cache_way_array #(
    parameter int WAYS   = 8,
    parameter int SETS   = 1,
    parameter int IDX_W  = 1,
    parameter int TAG_W  = 30,
    parameter int DATA_W = 32,
    parameter int WAY_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TAG_W-1:0]  tag,
    output logic              hit,
    output logic [WAY_W-1:0]  hit_way,
    output logic              inv_found,
    output logic [WAY_W-1:0]  inv_way,
    input  logic [WAY_W-1:0]  rd_way,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [WAY_W-1:0]  wr_way,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_dirty
);

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS];

    // lowest-numbered match / free way wins
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag) && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign rd_valid = valid_q[idx][rd_way];
    assign rd_dirty = dirty_q[idx][rd_way];
    assign rd_tag   = tag_q[idx][rd_way];
    assign rd_data  = data_q[idx][rd_way];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else if (wr_en) begin
            valid_q[idx][wr_way] <= 1'b1;
            dirty_q[idx][wr_way] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[idx][wr_way]  <= wr_tag;
            data_q[idx][wr_way] <= wr_data;
        end
    end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// rtl/assoc_cache_ctrl.sv - write-back write-allocate set-associative cache; CACHE_STATS_EN adds hit/miss counters
module assoc_cache_ctrl
    import cache_structs_def::*;
#(
    parameter int ADDR_WIDTH     = CACHE_ADDR_WIDTH,
    parameter int DATA_WIDTH     = CACHE_DATA_WIDTH,
    parameter int CACHE_SIZE     = 32,
    parameter int BLOCK_SIZE     = 4,
    parameter int NUMBER_OF_SETS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    assoc_cache_ctrl_if.slave     bus,
    inout  wire  [DATA_WIDTH-1:0] proc_req_data
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int WAYS     = CACHE_SIZE / (BLOCK_SIZE * NUMBER_OF_SETS);
    localparam int WAY_W    = $clog2(WAYS);
    localparam int OFF_W    = $clog2(BLOCK_SIZE);
    localparam int IDX_BITS = $clog2(NUMBER_OF_SETS);
    localparam int IDX_W    = (IDX_BITS == 0) ? 1 : IDX_BITS;
    localparam int TAG_W    = ADDR_WIDTH - OFF_W - IDX_BITS;

    cache_state_t          state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rw_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  hit_q;
    logic [WAY_W-1:0]      victim_q;
    logic                  use_ptr_q;
    memory_request_t       mem_req_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_oe_q;
    logic                  dr_q;
    logic                  hit_out_q;
    logic [WAY_W-1:0]      ptr_q [NUMBER_OF_SETS];

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic                  inv_found;
    logic [WAY_W-1:0]      inv_way;
    logic [WAY_W-1:0]      victim_way;
    logic                  rd_valid;
    logic                  rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] victim_addr;
    logic                  wr_en;
    logic [WAY_W-1:0]      wr_way;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_dirty;

    assign tag = addr_q[ADDR_WIDTH-1 -: TAG_W];

    generate
        if (IDX_BITS == 0) begin : g_one_set
            assign idx = '0;
        end else begin : g_sets
            assign idx = addr_q[OFF_W +: IDX_BITS];
        end
    endgenerate

    assign victim_way  = inv_found ? inv_way : ptr_q[idx];
    assign victim_addr = (ADDR_WIDTH'(rd_tag) << (OFF_W + IDX_BITS)) | (ADDR_WIDTH'(idx) << OFF_W);

    cache_way_array #(
        .WAYS   (WAYS),
        .SETS   (NUMBER_OF_SETS),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_WIDTH),
        .WAY_W  (WAY_W)
    ) u_ways (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .tag       (tag),
        .hit       (hit),
        .hit_way   (hit_way),
        .inv_found (inv_found),
        .inv_way   (inv_way),
        .rd_way    (hit ? hit_way : victim_way),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_way    (wr_way),
        .wr_tag    (tag),
        .wr_data   (wr_data),
        .wr_dirty  (wr_dirty)
    );

    // write hits update in place; allocation installs either processor or fetched data
    always_comb begin
        wr_en    = 1'b0;
        wr_way   = victim_q;
        wr_data  = wdata_q;
        wr_dirty = 1'b1;
        case (state)
            COMPARE: begin
                if (hit && rw_q) begin
                    wr_en  = 1'b1;
                    wr_way = hit_way;
                end
            end
            ALLOCATE: begin
                if (rw_q) begin
                    wr_en = 1'b1;
                end else if (mem_req_q.valid && bus.mem_res.ready) begin
                    wr_en    = 1'b1;
                    wr_data  = bus.mem_res.data;
                    wr_dirty = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            hit_q     <= 1'b0;
            victim_q  <= '0;
            use_ptr_q <= 1'b0;
            mem_req_q <= '0;
            rd_data_q <= '0;
            rd_oe_q   <= 1'b0;
            dr_q      <= 1'b0;
            hit_out_q <= 1'b0;
            for (int s = 0; s < NUMBER_OF_SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else begin
            dr_q      <= 1'b0;
            rd_oe_q   <= 1'b0;
            hit_out_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.proc_req.cs) begin
                        addr_q  <= bus.proc_req.addr;
                        rw_q    <= bus.proc_req.rw;
                        wdata_q <= proc_req_data;
                        state   <= COMPARE;
                    end
                end
                COMPARE: begin
                    hit_q     <= hit;
                    victim_q  <= victim_way;
                    use_ptr_q <= !inv_found;
                    if (hit) begin
                        rd_data_q <= rd_data;
                        state     <= DONE;
                    end else if (rd_valid && rd_dirty) begin
                        mem_req_q <= '{addr: victim_addr, data: rd_data, rw: 1'b1, valid: 1'b1};
                        state     <= WRITE_BACK;
                    end else begin
                        state <= ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    if (bus.mem_res.ready) begin
                        mem_req_q.valid <= 1'b0;
                        state           <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    // valid is always low on entry, so a read fetch is issued one cycle in
                    if (rw_q) begin
                        if (use_ptr_q) ptr_q[idx] <= ptr_q[idx] + WAY_W'(1);
                        state <= DONE;
                    end else if (!mem_req_q.valid) begin
                        mem_req_q <= '{addr: addr_q, data: '0, rw: 1'b0, valid: 1'b1};
                    end else if (bus.mem_res.ready) begin
                        mem_req_q.valid <= 1'b0;
                        rd_data_q       <= bus.mem_res.data;
                        if (use_ptr_q) ptr_q[idx] <= ptr_q[idx] + WAY_W'(1);
                        state <= DONE;
                    end
                end
                DONE: begin
                    dr_q      <= 1'b1;
                    hit_out_q <= hit_q;
                    rd_oe_q   <= !rw_q;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.proc_req_dr = dr_q;
    assign bus.hit_out     = hit_out_q;
    assign proc_req_data   = rd_oe_q ? rd_data_q : 'z;

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == COMPARE) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// tb/tb_assoc_cache_ctrl.sv - directed vector bench for assoc_cache_ctrl with a latency-2 word RAM model
module tb_assoc_cache_ctrl;
    import cache_structs_def::*;

    logic        clk;
    logic        rst;
    logic        tb_oe;
    logic [31:0] tb_wdata;
    wire  [31:0] proc_req_data;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_tests;
    int n_fail;

    assoc_cache_ctrl_if bus();

    assoc_cache_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .proc_req_data (proc_req_data)
`ifdef CACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    assign proc_req_data = tb_oe ? tb_wdata : 'z;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic            mem_busy;
    memory_request_t mem_q;
    logic [31:0]     mem_model [256];
    int              mem_wr_cnt;
    int              mem_rd_cnt;

    // ready follows two cycles after valid is first seen; the cycle after ready is ignored
    always @(posedge clk) begin
        if (rst) begin
            mem_busy   <= 1'b0;
            bus.mem_res <= '0;
            mem_wr_cnt <= 0;
            mem_rd_cnt <= 0;
            for (int i = 0; i < 256; i++) mem_model[i] <= '0;
            mem_model[8'h2a] <= 32'h0000_0055;
        end else begin
            bus.mem_res.ready <= 1'b0;
            if (mem_busy) begin
                bus.mem_res.ready <= 1'b1;
                mem_busy <= 1'b0;
                if (mem_q.rw) begin
                    mem_model[mem_q.addr[9:2]] <= mem_q.data;
                    mem_wr_cnt <= mem_wr_cnt + 1;
                end else begin
                    bus.mem_res.data <= mem_model[mem_q.addr[9:2]];
                    mem_rd_cnt <= mem_rd_cnt + 1;
                end
            end else if (bus.mem_req.valid && !bus.mem_res.ready) begin
                mem_busy <= 1'b1;
                mem_q    <= bus.mem_req;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // lat counts clock edges from the one that samples cs (=1) to the one after which dr is seen
    task automatic do_access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                             output logic hit, output logic [31:0] rdata,
                             output int lat, output int nwr, output int nrd);
        int wr0;
        int rd0;
        @(negedge clk);
        wr0 = mem_wr_cnt;
        rd0 = mem_rd_cnt;
        bus.proc_req = '{addr: addr, rw: rw, cs: 1'b1};
        tb_wdata = wdata;
        tb_oe = rw;
        @(posedge clk);
        #1;
        bus.proc_req.cs = 1'b0;
        tb_oe = 1'b0;
        lat = 1;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.proc_req_dr) break;
        end
        hit   = bus.hit_out;
        rdata = proc_req_data;
        nwr   = mem_wr_cnt - wr0;
        nrd   = mem_rd_cnt - rd0;
    endtask

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_hit;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic        hit;
        logic [31:0] rdata;
        int          lat;
        int          nwr;
        int          nrd;
        int          waited;

        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        tb_oe    = 1'b0;
        tb_wdata = '0;
        bus.proc_req = '0;

        vecs[0]  = '{1'b1, 32'h000, 32'hbeefdead, 1'b0, 32'h0,        4,  0, 0};
        vecs[1]  = '{1'b1, 32'h000, 32'hbeefdead, 1'b1, 32'h0,        3,  0, 0};
        vecs[2]  = '{1'b1, 32'h020, 32'hbeefdead, 1'b0, 32'h0,        4,  0, 0};
        vecs[3]  = '{1'b1, 32'h040, 32'hbeefdead, 1'b0, 32'h0,        4,  0, 0};
        vecs[4]  = '{1'b1, 32'h060, 32'hbeefdead, 1'b0, 32'h0,        4,  0, 0};
        vecs[5]  = '{1'b1, 32'h080, 32'hbeefdead, 1'b0, 32'h0,        4,  0, 0};
        vecs[6]  = '{1'b0, 32'h040, 32'h0,        1'b1, 32'hbeefdead, 3,  0, 0};
        vecs[7]  = '{1'b1, 32'h0a0, 32'hbeefdead, 1'b0, 32'h0,        4,  0, 0};
        vecs[8]  = '{1'b1, 32'h0c0, 32'hbeefdead, 1'b0, 32'h0,        4,  0, 0};
        vecs[9]  = '{1'b1, 32'h0e0, 32'hbeefdead, 1'b0, 32'h0,        4,  0, 0};
        vecs[10] = '{1'b1, 32'h100, 32'h12345678, 1'b0, 32'h0,        7,  1, 0};
        vecs[11] = '{1'b0, 32'h0aa, 32'h0,        1'b0, 32'h55,       10, 1, 1};
        vecs[12] = '{1'b0, 32'h0aa, 32'h0,        1'b1, 32'h55,       3,  0, 0};
        vecs[13] = '{1'b0, 32'h100, 32'h0,        1'b1, 32'h12345678, 3,  0, 0};
        vecs[14] = '{1'b0, 32'h000, 32'h0,        1'b0, 32'hbeefdead, 10, 1, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset dr", {31'd0, bus.proc_req_dr}, 32'd0);
        check("reset hit_out", {31'd0, bus.hit_out}, 32'd0);
        check("reset mem valid", {31'd0, bus.mem_req.valid}, 32'd0);
`ifdef CACHE_STATS_EN
        check("reset hit_count", hit_count, 32'd0);
        check("reset miss_count", miss_count, 32'd0);
`endif

        for (int i = 0; i < 15; i++) begin
            do_access(vecs[i].rw, vecs[i].addr, vecs[i].wdata, hit, rdata, lat, nwr, nrd);
            check($sformatf("v%0d hit", i), {31'd0, hit}, {31'd0, vecs[i].exp_hit});
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d mem writes", i), nwr, vecs[i].exp_wr);
            check($sformatf("v%0d mem reads", i), nrd, vecs[i].exp_rd);
            if (!vecs[i].rw) check($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
        end

        check("wb data addr 0x00", mem_model[8'h00], 32'hbeefdead);
        check("wb data addr 0x20", mem_model[8'h08], 32'hbeefdead);
        check("wb data addr 0x40", mem_model[8'h10], 32'hbeefdead);
`ifdef CACHE_STATS_EN
        check("hit_count", hit_count, 32'd4);
        check("miss_count", miss_count, 32'd11);
`endif

        // reset while a dirty victim (0x60) is being written back
        @(negedge clk);
        bus.proc_req = '{addr: 32'h200, rw: 1'b1, cs: 1'b1};
        tb_wdata = 32'hcafef00d;
        tb_oe = 1'b1;
        @(posedge clk);
        #1;
        bus.proc_req.cs = 1'b0;
        tb_oe = 1'b0;
        waited = 0;
        while (!(bus.mem_req.valid && bus.mem_req.rw) && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("write-back started", {31'd0, bus.mem_req.valid & bus.mem_req.rw}, 32'd1);
        check("write-back addr", bus.mem_req.addr, 32'h060);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst mid wb valid", {31'd0, bus.mem_req.valid}, 32'd0);
        check("rst mid wb dr", {31'd0, bus.proc_req_dr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_access(1'b0, 32'h100, 32'h0, hit, rdata, lat, nwr, nrd);
        check("post-rst 0x100 hit", {31'd0, hit}, 32'd0);
        check("post-rst 0x100 latency", lat, 7);
        check("post-rst 0x100 mem reads", nrd, 1);
        check("post-rst 0x100 rdata", rdata, 32'h0);
        do_access(1'b0, 32'h100, 32'h0, hit, rdata, lat, nwr, nrd);
        check("post-rst 0x100 rehit", {31'd0, hit}, 32'd1);
        check("post-rst 0x100 rehit latency", lat, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
